dec_seq: RTL
============

# dec_seq

Parametrised registered one-hot decoder with an internal step index, successor to the fixed 3-to-8 decoder. It holds an index register that can be loaded directly, stepped, or cleared. It drives a registered one-hot output `Y` gated by an enable. It is used in the processor control path both as the register-select decoder (load mode) and as the time-step sequencer (step mode, replacing a separate counter plus decoder).

## Interface
- `WIDTH`, default 3: index width; output count `OUTS = 2**WIDTH`.
- `LAST`, default `2**WIDTH-1`: highest index reached by stepping; range 0..OUTS-1.

- `Clock`  in  1  rising-edge clock.
- `Resetn`  in  1  asynchronous, active-low reset.
- `En`  in  1  output enable; gates `Y` only, never the index.
- `Clear`  in  1  synchronous index clear to 0.
- `Load`  in  1  load `W` into the index.
- `W`  in  WIDTH  load value.
- `Step`  in  1  advance the index by one.
- `Idx`  out  WIDTH  current index register.
- `Y`  out  [0:OUTS-1]  registered one-hot; `Y[0]` corresponds to index 0.
- `Wrap`  out  1  registered status flag; see Configuration.

## Operation
- Index next-state priority: `Clear` > `Load` > `Step` > hold.
  - `Clear` gives 0.
  - `Load` gives `W`, taken as-is, even if it exceeds `LAST`.
  - `Step` with `Idx < LAST` gives `Idx+1`.
  - `Step` with `Idx >= LAST` gives 0 (wrap).
- `Y <= En ? onehot(idx_next) : 0`, so `Y` always matches the value `Idx` holds after the same edge.
- With `En=0`, `Y` is all zeros while the index keeps evolving. When `En` rises, `Y` shows the current index on the next edge.
- Exactly one bit of `Y` is set whenever the registered `En` is 1; otherwise no bits are set.
- `Wrap` is a one-cycle pulse, registered on the edge where a `Step` causes the wrap. It is suppressed if `Clear` or `Load` is active in the same cycle.
- All index arithmetic is modulo `2**WIDTH` with no overflow beyond `LAST`.

## Timing
- Reset values: `Idx=0`, `Y=0` (all bits), `Wrap=0`. These take effect immediately on `Resetn` low, independent of `Clock`.
- Reset asserted mid-sequence discards the index. After `Resetn` rises, the first edge with `En=1` gives `Y[0]=1`.
- Latency from any control input to `Idx`, `Y` and `Wrap` is 1 clock edge. Nothing is combinational from input to output.
- Continuous `Step` with `LAST=L` gives period `L+1` cycles, with a `Wrap` pulse once per period, in the cycle when `Idx` returns to 0.
- Simultaneous `Load` and `Step`: load wins and the index does not step.
- Simultaneous `Clear` and `Load`: the index becomes 0.

## Configuration
- Macro: `DEC_SEQ_SATURATE_EN`.
- Undefined (default): wrap behaviour as above. `Wrap` is a pulse.
- Defined:
  - `Step` at `Idx >= LAST` holds the index and does not wrap.
  - `Wrap` becomes a registered level, 1 while `Idx == LAST`, and is updated on the same edge as `Idx`.
  - `Clear` and `Load` remain the only ways to leave `LAST`.

## Structure
- Shared include `dec_defs.vh` holds:
  - default `WIDTH` and `LAST` for the processor instances (register select: `WIDTH=3`; time-step sequencer: `WIDTH=2`, `LAST=3`);
  - the `OUTS` computation macro.
- Sub-module `dec_onehot` (combinational, parameter `WIDTH`; inputs `W`, `En`; output `Y[0:2**WIDTH-1]`) generalises the old decoder. It is instantiated once on `idx_next`, with its output registered in `dec_seq`.

## Test plan
- Reset, `WIDTH=3`, hold `Resetn` low, then release with `En=1` and no controls → `Idx=0`, `Y=10000000` after the first edge, `Wrap=0`.
- `Load` with `W=5` and `En=1` → next edge: `Idx=5`, `Y=00000100`. Then `En=0` → `Y=00000000` and `Idx` stays 5.
- `WIDTH=2`, `LAST=3`, continuous `Step` from 0 → `Y` cycles 1000, 0100, 0010, 0001, 1000. `Wrap=1` only in the cycle `Idx` returns to 0.
- `LAST=2`, `Load` with `W=3`, then `Step` → `Idx=0` and a `Wrap` pulse. `Clear`, `Load` and `Step` together → `Idx=0` and no `Wrap`.
- `Resetn` pulsed low while `Idx=6` → `Y` and `Idx` are 0 immediately, without waiting for a clock edge.
- With `DEC_SEQ_SATURATE_EN` defined, `LAST=3`, 6 consecutive `Step` pulses → `Idx` holds at 3 with `Wrap` high from the edge `Idx` reaches 3. `Clear` → `Idx=0` and `Wrap=0`.

Source files
------------

// File: rtl/dec_seq_pkg.sv
// dec_seq_pkg: shared defaults, next-state op encoding and output-count helper for dec_seq
//   REG_SEL_*  : register-select decoder instance defaults (load mode)
//   TSTEP_*    : time-step sequencer instance defaults (step mode)
//   outs()     : number of one-hot outputs for a given index width
package dec_seq_pkg;
  localparam int REG_SEL_WIDTH = 3;
  localparam int REG_SEL_LAST = 7;
  localparam int TSTEP_WIDTH = 2;
  localparam int TSTEP_LAST = 3;
  typedef enum logic [1:0] {OP_HOLD, OP_STEP, OP_LOAD, OP_CLEAR} op_e;
  function automatic int outs(input int width);
    return 1 << width;
  endfunction
endpackage

// File: rtl/dec_seq_if.sv
// dec_seq_if: control/status bundle for dec_seq
//   master drives En, Clear, Load, W, Step and observes Idx, Y, Wrap
//   slave (the decoder) receives controls and drives Idx, Y, Wrap
interface dec_seq_if #(parameter int WIDTH = 3);
  logic En;
  logic Clear;
  logic Load;
  logic [WIDTH-1:0] W;
  logic Step;
  logic [WIDTH-1:0] Idx;
  logic [0:(1<<WIDTH)-1] Y;
  logic Wrap;
  modport master (output En, Clear, Load, W, Step, input Idx, Y, Wrap);
  modport slave (input En, Clear, Load, W, Step, output Idx, Y, Wrap);
endinterface

// File: rtl/dec_onehot.sv
// dec_onehot: combinational WIDTH-to-2**WIDTH one-hot decoder with enable
//   W  : index to decode
//   En : when low all outputs are zero
//   Y  : one-hot, Y[0] corresponds to W == 0
module dec_onehot #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] W,
  input  logic En,
  output logic [0:(1<<WIDTH)-1] Y
);
  for (genvar i = 0; i < (1 << WIDTH); i++) begin : g_dec
    assign Y[i] = En && (W == WIDTH'(i));
  end
endmodule

// File: rtl/dec_seq.sv
// dec_seq: registered one-hot decoder with loadable / steppable / clearable index
//   Clock  : rising-edge clock
//   Resetn : asynchronous active-low reset (Idx=0, Y=0, Wrap=0)
//   bus    : dec_seq_if slave -- En, Clear, Load, W, Step in; Idx, Y, Wrap out
//   Optional macro DEC_SEQ_SATURATE_EN: stepping saturates at LAST and Wrap
//   becomes a level flag meaning Idx == LAST; otherwise stepping wraps to 0
//   and Wrap pulses for one cycle on the wrapping edge.
module dec_seq
  import dec_seq_pkg::*;
#(
  parameter int WIDTH = REG_SEL_WIDTH,
  parameter int LAST = (1 << WIDTH) - 1
) (
  input logic Clock,
  input logic Resetn,
  dec_seq_if.slave bus
);
  localparam int OUTS = outs(WIDTH);
  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);
  op_e op;
  logic [WIDTH-1:0] idx_q, idx_next;
  logic [0:OUTS-1] y_next, y_q;
  logic at_last, wrap_next, wrap_q;
  always_comb begin
    op = bus.Clear ? OP_CLEAR : bus.Load ? OP_LOAD : bus.Step ? OP_STEP : OP_HOLD;
    // >= rather than == so a loaded index above LAST still leaves via the wrap path
    at_last = idx_q >= LAST_V;
`ifdef DEC_SEQ_SATURATE_EN
    idx_next = op == OP_CLEAR ? '0 : op == OP_LOAD ? bus.W :
               (op == OP_STEP && !at_last) ? idx_q + 1'b1 : idx_q;
    wrap_next = idx_next == LAST_V;
`else
    idx_next = op == OP_CLEAR ? '0 : op == OP_LOAD ? bus.W :
               op == OP_STEP ? (at_last ? '0 : idx_q + 1'b1) : idx_q;
    wrap_next = op == OP_STEP && at_last;
`endif
  end
  // decode the next index so Y lines up with Idx after the same edge
  dec_onehot #(.WIDTH(WIDTH)) u_onehot (
    .W(idx_next),
    .En(bus.En),
    .Y(y_next)
  );
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      idx_q <= '0;
      y_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q <= idx_next;
      y_q <= y_next;
      wrap_q <= wrap_next;
    end
  end
  assign bus.Idx = idx_q;
  assign bus.Y = y_q;
  assign bus.Wrap = wrap_q;
endmodule
